// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if: request/response bundle between the EX stage and the sequential
// divider.
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held by EX until ready_o is seen
//   annul_i       abort the current or pending divide
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
//   busy_o        divider occupied (stall request)
// Modports: master = EX side, slave = divider side.
// ---------------------------------------------------------------------------
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit per clock; DATA_W iterations plus one sign-fix edge.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   div_if.slave (operands, start/annul in; result/ready/busy out)
// result_o = {remainder, quotient}: upper half to HI, lower half to LO.
// ---------------------------------------------------------------------------
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int            CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic              q_neg;
  logic              r_neg;

  // Operand magnitudes and one iteration of the shift/subtract datapath.
  logic              sign1;
  logic              sign2;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;
  logic              trial_ok;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  // NOTE: every signal gets a value before any condition, so no latch is inferred.
  always_comb begin
    sign1    = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    sign2    = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    abs1     = sign1 ? -bus.opdata1_i : bus.opdata1_i;
    abs2     = sign2 ? -bus.opdata2_i : bus.opdata2_i;
    // The shifted partial remainder can exceed DATA_W bits before the
    // subtraction, so the trial is done one bit wider.
    rem_sh   = {rem, quo[DATA_W-1]};
    diff     = rem_sh - {1'b0, divisor};
    trial_ok = (rem_sh >= {1'b0, divisor});
    rem_next = trial_ok ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_next = {quo[DATA_W-2:0], trial_ok};
    quo_fix  = q_neg ? -quo : quo;
    rem_fix  = r_neg ? -rem : rem;
  end

  // NOTE: state uses non-blocking assignments so all registers update together on the edge.
  // NOTE: the datapath registers are reset too, so nothing from an aborted divide survives rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      divisor      <= '0;
      rem          <= '0;
      quo          <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
      bus.busy_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // annul_i wins over start_i.
          if (bus.start_i && !bus.annul_i) begin
            bus.busy_o <= 1'b1;
            if (bus.opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state   <= S_ON;
              cnt     <= '0;
              rem     <= '0;
              quo     <= abs1;
              divisor <= abs2;
              q_neg   <= sign1 ^ sign2;
              r_neg   <= sign1;
            end
          end
        end

        S_BYZERO: begin
          bus.busy_o <= 1'b0;
          if (bus.annul_i) begin
            state <= S_IDLE;
          end else begin
            state        <= S_END;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b1;
          end
        end

        S_ON: begin
          if (bus.annul_i) begin
            state      <= S_IDLE;
            bus.busy_o <= 1'b0;
          end else if (cnt == LAST_CNT) begin
            // All quotient bits are in; apply signs and present the result.
            state        <= S_END;
            bus.busy_o   <= 1'b0;
            bus.ready_o  <= 1'b1;
            bus.result_o <= {rem_fix, quo_fix};
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
          end
        end

        S_END: begin
          // Hold the result until EX drops its request (or a flush hits).
          if (!bus.start_i || bus.annul_i) begin
            state        <= S_IDLE;
            bus.ready_o  <= 1'b0;
            bus.result_o <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq: directed self-checking bench for div_seq.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_div_seq;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div_if #(.DATA_W(W)) bus ();

  div_seq #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one divide from IDLE with start held, scrambling operands after
  // the accepting edge. elat counts edges including the accepting one.
  task automatic run_div(input string name, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int elat, input int ebusy);
    int   edges;
    int   busy_cycles;
    bit   seen;
    logic [2*W-1:0] exp_res;
    exp_res = {er, eq};
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    edges       = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    while (!seen && edges < 100) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = b ^ 32'h0000_0005;
        bus.signed_div_i = ~sgn;
      end
      if (bus.busy_o === 1'b1) busy_cycles++;
      if (bus.ready_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || edges != elat) begin
      failures++;
      $display("FAIL %s latency: got %0d edges (ready seen=%0d), expected %0d", name, edges, seen, elat);
    end
    checks++;
    if (bus.result_o !== exp_res) begin
      failures++;
      $display("FAIL %s result: got %h, expected %h", name, bus.result_o, exp_res);
    end
    checks++;
    if (busy_cycles != ebusy) begin
      failures++;
      $display("FAIL %s busy cycles: got %0d, expected %0d", name, busy_cycles, ebusy);
    end
    // Start still held: result must be held.
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== exp_res) begin
      failures++;
      $display("FAIL %s hold: ready=%b result=%h, expected ready=1 result=%h", name, bus.ready_o, bus.result_o, exp_res);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== '0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL %s release: ready=%b busy=%b result=%h, expected all 0", name, bus.ready_o, bus.busy_o, bus.result_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== '0) begin
      failures++;
      $display("FAIL reset outputs: ready=%b busy=%b result=%h, expected all 0", bus.ready_o, bus.busy_o, bus.result_o);
    end
    apply_reset();
    checks++;
    if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== '0) begin
      failures++;
      $display("FAIL post-reset idle: ready=%b busy=%b result=%h, expected all 0", bus.ready_o, bus.busy_o, bus.result_o);
    end
  endtask

  task automatic test_divu();
    run_div("divu_100_7",   1'b0, 32'd100,       32'd7,  32'd14,        32'd2,   34, 33);
    run_div("divu_5_9",     1'b0, 32'd5,         32'd9,  32'd0,         32'd5,   34, 33);
    run_div("divu_max_16",  1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'hF,   34, 33);
  endtask

  task automatic test_div_signed();
    run_div("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 33);
    run_div("div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         34, 33);
    run_div("div_m7_m2",    1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 34, 33);
    run_div("div_m100_7",   1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 34, 33);
  endtask

  task automatic test_div_zero();
    run_div("div_5_0",      1'b1, 32'd5,         32'd0, 32'd0, 32'd0, 2, 1);
    run_div("divu_max_0",   1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 2, 1);
  endtask

  task automatic test_overflow();
    run_div("div_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         34, 33);
    run_div("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34, 33);
  endtask

  task automatic test_annul();
    bit seen;
    // annul_i has priority over start_i in IDLE.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd50;
    bus.opdata2_i    = 32'd5;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL annul_idle: busy=%b ready=%b, expected 0 0", bus.busy_o, bus.ready_o);
    end
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(negedge clk);

    // annul in BYZERO returns to IDLE without a result.
    bus.opdata2_i = 32'd0;
    bus.start_i   = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL annul_byzero busy: got %b, expected 1", bus.busy_o);
    end
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== '0) begin
      failures++;
      $display("FAIL annul_byzero: busy=%b ready=%b result=%h, expected all 0", bus.busy_o, bus.ready_o, bus.result_o);
    end
    bus.annul_i = 1'b0;
    @(negedge clk);

    // annul mid-iteration, then no result ever appears.
    bus.opdata1_i = 32'hFFFF_FFFF;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL annul_on: busy=%b ready=%b, expected 0 0", bus.busy_o, bus.ready_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL annul_quiet: ready/busy asserted after annul, expected 0");
    end
    run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, 33);
  endtask

  task automatic test_async_reset();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd10;
    bus.start_i      = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL async_rst pre busy: got %b, expected 1", bus.busy_o);
    end
    #2;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== '0) begin
      failures++;
      $display("FAIL async_rst: busy=%b ready=%b result=%h, expected all 0", bus.busy_o, bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_div("after_rst_1000_10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34, 33);
  endtask

  task automatic test_back_to_back();
    run_div("b2b_first",  1'b0, 32'd81,        32'd9, 32'd9, 32'd0, 34, 33);
    run_div("b2b_second", 1'b1, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 34, 33);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
